// File: rtl/oled_iic_responder.sv
// oled_iic_responder: SSD1306-style I2C write responder for simulation and loopback builds.
// Oversamples SCL/SDA, ACKs its write address and strobes decoded command/data bytes.
`timescale 1ns/1ps
module oled_iic_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       iic_scl,
  inout  wire        iic_sda,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_is_arg,
  output logic       data_valid,
  output logic [7:0] data_byte,
  output logic [6:0] data_col,
  output logic [2:0] data_page,
  output logic       frame_done
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_CTRL, ST_CTRL_ACK, ST_PAYLOAD, ST_PAYLOAD_ACK, ST_IGNORE
  } state_t;

  state_t      state_q;
  logic        scl_s1_q, scl_s2_q, scl_d_q;
  logic        sda_s1_q, sda_s2_q, sda_d_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        rx_done_q, co_q, dc_q, addressed_q, sda_oe_q;
  logic [1:0]  arg_cnt_q;
  logic [2:0]  page_q;
  logic [6:0]  col_q;

  logic scl_rise, scl_fall, bus_start, bus_stop, in_ack, in_rx;

  function automatic logic [1:0] arg_count(input logic [7:0] b);
    case (b)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: arg_count = 2'd1;
      8'h21, 8'h22:                                                   arg_count = 2'd2;
      default:                                                        arg_count = 2'd0;
    endcase
  endfunction

  assign iic_sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  assign bus_start = scl_s2_q & sda_d_q & ~sda_s2_q;
  assign bus_stop  = scl_s2_q & ~sda_d_q & sda_s2_q;
  assign in_ack    = (state_q == ST_ADDR_ACK) || (state_q == ST_CTRL_ACK) || (state_q == ST_PAYLOAD_ACK);
  assign in_rx     = (state_q == ST_ADDR) || (state_q == ST_CTRL) || (state_q == ST_PAYLOAD);

  // Two-flop synchronizers plus one delay stage for edge detection; idle bus reads high.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_d_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_d_q <= 1'b1;
    end else begin
      scl_s1_q <= iic_scl;  scl_s2_q <= scl_s1_q; scl_d_q <= scl_s2_q;
      sda_s1_q <= iic_sda;  sda_s2_q <= sda_s1_q; sda_d_q <= sda_s2_q;
    end
  end

  // Protocol FSM: bus events, bit shifting, byte decode, ACK drive and output strobes.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      rx_done_q   <= 1'b0;
      co_q        <= 1'b0;
      dc_q        <= 1'b0;
      addressed_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      arg_cnt_q   <= 2'd0;
      page_q      <= 3'd0;
      col_q       <= 7'd0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'd0;
      cmd_is_arg  <= 1'b0;
      data_valid  <= 1'b0;
      data_byte   <= 8'd0;
      data_col    <= 7'd0;
      data_page   <= 3'd0;
      frame_done  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      if (bus_stop) begin
        state_q     <= ST_IDLE;
        bit_cnt_q   <= 4'd0;
        sda_oe_q    <= 1'b0;
        arg_cnt_q   <= 2'd0;
        rx_done_q   <= 1'b0;
        frame_done  <= addressed_q;
        addressed_q <= 1'b0;
      end else if (bus_start) begin
        state_q     <= ST_ADDR;
        bit_cnt_q   <= 4'd0;
        sda_oe_q    <= 1'b0;
        arg_cnt_q   <= 2'd0;
        rx_done_q   <= 1'b0;
        addressed_q <= 1'b0;
      end else if (rx_done_q) begin
        // A full byte sits in shift_q; decode it one clock after the last bit.
        rx_done_q <= 1'b0;
        case (state_q)
          ST_ADDR: begin
            if (shift_q == {SLAVE_ADDR, 1'b0}) begin
              state_q     <= ST_ADDR_ACK;
              addressed_q <= 1'b1;
            end else begin
              state_q <= ST_IGNORE;
            end
          end
          ST_CTRL: begin
            co_q    <= shift_q[7];
            dc_q    <= shift_q[6];
            state_q <= ST_CTRL_ACK;
          end
          ST_PAYLOAD: begin
            state_q <= ST_PAYLOAD_ACK;
            if (dc_q) begin
              data_valid <= 1'b1;
              data_byte  <= shift_q;
              data_col   <= col_q;
              data_page  <= page_q;
              col_q      <= col_q + 7'd1;
            end else begin
              cmd_valid <= 1'b1;
              cmd_byte  <= shift_q;
              if (arg_cnt_q != 2'd0) begin
                cmd_is_arg <= 1'b1;
                arg_cnt_q  <= arg_cnt_q - 2'd1;
              end else begin
                cmd_is_arg <= 1'b0;
                arg_cnt_q  <= arg_count(shift_q);
                if (shift_q[7:3] == 5'b10110) begin
                  page_q <= shift_q[2:0];
                end else if (shift_q[7:4] == 4'h0) begin
                  col_q[3:0] <= shift_q[3:0];
                end else if (shift_q[7:3] == 5'b00010) begin
                  col_q[6:4] <= shift_q[2:0];
                end
              end
            end
          end
          default: ;
        endcase
      end else begin
        if (scl_rise) begin
          if (in_ack && (bit_cnt_q == 4'd8)) begin
            bit_cnt_q <= 4'd0;
            case (state_q)
              ST_ADDR_ACK: state_q <= ST_CTRL;
              ST_CTRL_ACK: state_q <= ST_PAYLOAD;
              default:     state_q <= co_q ? ST_CTRL : ST_PAYLOAD;
            endcase
          end else if (in_rx && (bit_cnt_q < 4'd8)) begin
            shift_q   <= {shift_q[6:0], sda_s2_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            rx_done_q <= (bit_cnt_q == 4'd7);
          end
        end
        // ACK window: grab SDA on the fall after the byte, release on the following fall.
        if (scl_fall) begin
          if (sda_oe_q) begin
            sda_oe_q <= 1'b0;
          end else if (in_ack && (bit_cnt_q == 4'd8)) begin
            sda_oe_q <= 1'b1;
          end
        end
      end
    end
  end
endmodule
